// File: rtl/div32_seq_pkg.sv
// Shared constants, state encoding and negation helper for the iterative divider.
package div32_seq_pkg;

  localparam int ITER_DEF = 32;
  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's complement negation as plain invert-plus-one, modulo 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div32_seq_full_add32.sv
// 32-bit adder with carry in/out; the divider uses it as its trial subtractor.
module full_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/div32_seq.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, quotient to LO (q)
// and remainder to HI (r), sign fix-up in a final cycle.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = ITER_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [31:0] dvd_r;      // dividend magnitude, shifted out MSB-first; quotient shifts in at LSB
  logic [31:0] bmag_r;
  logic [31:0] rem_r;
  logic [31:0] a_raw_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        div0_r;

  logic [31:0] rem_sh_s;
  logic [31:0] diff_s;
  logic        cout_s;
  logic        take_s;
  logic [31:0] rem_nxt_s;

  assign rem_sh_s = {rem_r[30:0], dvd_r[31]};

  full_add32 u_sub (
    .a    (rem_sh_s),
    .b    (~bmag_r),
    .cin  (1'b1),
    .sum  (diff_s),
    .cout (cout_s)
  );

  // The bit shifted out of the remainder MSB makes the shifted value exceed any divisor.
  assign take_s    = cout_s | rem_r[31];
  assign rem_nxt_s = take_s ? diff_s : rem_sh_s;

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      dvd_r   <= 32'd0;
      bmag_r  <= 32'd0;
      rem_r   <= 32'd0;
      a_raw_r <= 32'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      div0_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= 32'd0;
      r       <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_raw_r <= a;
            dvd_r   <= (sgn & a[31]) ? neg32(a) : a;
            bmag_r  <= (sgn & b[31]) ? neg32(b) : b;
            neg_q_r <= sgn & (a[31] ^ b[31]);
            neg_r_r <= sgn & a[31];
            div0_r  <= (b == 32'd0);
            rem_r   <= 32'd0;
            cnt_r   <= 5'd0;
            busy    <= 1'b1;
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          dvd_r <= {dvd_r[30:0], take_s};
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == LAST) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          // Divide by zero reports the raw dividend regardless of mode.
          if (div0_r) begin
            q <= DIV0_Q;
            r <= a_raw_r;
          end else begin
            q <= neg_q_r ? neg32(dvd_r) : dvd_r;
            r <= neg_r_r ? neg32(rem_r) : rem_r;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq.
module tb_div32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;

  int n_chk;
  int n_fail;
  int n;
  logic busy_ok;

  div32_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge: presents a start for one edge.
  task automatic launch(input logic s, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    sgn   = s;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'h0BAD_0BAD;
    b     = 32'h0000_0003;
  endtask

  // Counts edges until done is seen, bounded at 40.
  task automatic wait_done(output int cnt, output logic bok);
    cnt = 0;
    bok = 1'b1;
    while (!done && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!done && !busy) bok = 1'b0;
    end
  endtask

  task automatic op(input string tag, input logic s, input logic [31:0] av,
                    input logic [31:0] bv, input logic [31:0] eq, input logic [31:0] er);
    launch(s, av, bv);
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    wait_done(n, busy_ok);
    check({tag, "_latency"}, n, 32'd33);
    check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b0;
    sgn    = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);

    op("divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2);
    op("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    op("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    op("divu_big_2",  1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1);
    op("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    op("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0);
    op("divu_5_0",    1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5);
    op("div_5_0",     1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5);
    op("div_m5_0",    1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Reset in the middle of CALC aborts with no done pulse.
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_q", q, 32'd0);
    check("abort_r", r, 32'd0);
    wait_done(n, busy_ok);
    check("abort_no_done", {31'd0, done}, 32'd0);

    // A second start while busy is ignored.
    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    sgn   = 1'b1;
    a     = 32'd50;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, busy_ok);
    check("repulse_latency", n, 32'd28);
    check("repulse_q", q, 32'd14);
    check("repulse_r", r, 32'd2);

    // Back-to-back: new start in the done cycle.
    @(posedge clk);
    #1;
    launch(1'b0, 32'd100, 32'd7);
    wait_done(n, busy_ok);
    check("b2b_first_q", q, 32'd14);
    check("b2b_first_done", {31'd0, done}, 32'd1);
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    check("b2b_accept_busy", {31'd0, busy}, 32'd1);
    check("b2b_accept_done", {31'd0, done}, 32'd0);
    check("b2b_hold_q", q, 32'd14);
    check("b2b_hold_r", r, 32'd2);
    wait_done(n, busy_ok);
    check("b2b_latency", n, 32'd33);
    check("b2b_q", q, 32'hFFFF_FFFD);
    check("b2b_r", r, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
